eae_shifter: RTL and testbench

//  Multi-cycle EAE shift unit for the PDP-8 datapath: shifts the 25-bit L:AC:MQ chain one bit per clock.

---
 rtl/eae_shifter_pkg.sv | 23 ++
 rtl/eae_shifter_step.sv | 43 ++++
 rtl/eae_shifter.sv | 147 ++++++++++++++
 tb/tb_eae_shifter.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/eae_shifter_pkg.sv
// Shared definitions for the EAE shift unit: operation encodings,
// sequencer states and the normalize shift limit.
package eae_shifter_pkg;

    // Operation select as presented on the op port.
    typedef enum logic [1:0] {
        EAE_SHL = 2'b00,
        EAE_ASR = 2'b01,
        EAE_LSR = 2'b10,
        EAE_NMI = 2'b11
    } eae_op_e;

    // Sequencer states: accept a request, step once per clock, report.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } eae_state_e;

    // Normalize never shifts more than this many places.
    localparam int unsigned NMI_MAX = 23;

endpackage

// File: rtl/eae_shifter_step.sv
// Single-bit combinational step of the {L,AC,MQ} chain.
// SHL and NMI share the left-shift path; ASR replicates AC0 and copies it
// into the link; LSR feeds zero into AC0 and clears the link.
module eae_step
    import eae_shifter_pkg::*;
#(
    parameter int unsigned WIDTH = 12
) (
    input  eae_op_e          op,
    input  logic             l_in,
    input  logic [WIDTH-1:0] ac_in,
    input  logic [WIDTH-1:0] mq_in,
    output logic             l_out,
    output logic [WIDTH-1:0] ac_out,
    output logic [WIDTH-1:0] mq_out
);

    // Select one shift step according to the latched operation.
    always_comb begin
        l_out  = l_in;
        ac_out = ac_in;
        mq_out = mq_in;
        case (op)
            EAE_SHL, EAE_NMI: begin
                {l_out, ac_out, mq_out} = {ac_in, mq_in, 1'b0};
            end
            EAE_ASR: begin
                {ac_out, mq_out} = {ac_in[WIDTH-1], ac_in, mq_in[WIDTH-1:1]};
                l_out            = ac_in[WIDTH-1];
            end
            EAE_LSR: begin
                {ac_out, mq_out} = {1'b0, ac_in, mq_in[WIDTH-1:1]};
                l_out            = 1'b0;
            end
            default: begin
                l_out  = l_in;
                ac_out = ac_in;
                mq_out = mq_in;
            end
        endcase
    end

endmodule

// File: rtl/eae_shifter.sv
// EAE multi-cycle shift unit for the PDP-8 datapath.
// Shifts the 25-bit L:AC:MQ chain one bit per clock for counted SHL/ASR/LSR
// and for normalize (NMI). The sequencer pulses start, waits for done and
// then gates AC onto the bus with oe.
// Build option: define EAE_NMI_EN to implement normalize on op=11; without
// it op=11 loads the operands and completes with data unchanged and SC=0.
module eae_shifter
    import eae_shifter_pkg::*;
#(
    parameter int unsigned WIDTH  = 12,
    parameter int unsigned SCBITS = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [SCBITS-1:0] count,
    input  logic [WIDTH-1:0]  ac_in,
    input  logic [WIDTH-1:0]  mq_in,
    input  logic              l_in,
    input  logic              oe,
    output logic [WIDTH-1:0]  ac_out,
    output logic [WIDTH-1:0]  mq_out,
    output logic              l_out,
    output logic [SCBITS-1:0] sc_out,
    output logic              busy,
    output logic              done
);

    eae_state_e        state_q, state_d;
    eae_op_e           op_q, op_d;
    logic [WIDTH-1:0]  ac_q, ac_d;
    logic [WIDTH-1:0]  mq_q, mq_d;
    logic              l_q, l_d;
    logic [SCBITS-1:0] sc_q, sc_d;

    logic              step_l;
    logic [WIDTH-1:0]  step_ac;
    logic [WIDTH-1:0]  step_mq;

`ifdef EAE_NMI_EN
    logic              nmi_stop;
`endif

    eae_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .op     (op_q),
        .l_in   (l_q),
        .ac_in  (ac_q),
        .mq_in  (mq_q),
        .l_out  (step_l),
        .ac_out (step_ac),
        .mq_out (step_mq)
    );

`ifdef EAE_NMI_EN
    // Normalize halts before shifting once AC0 and AC1 differ, the operand
    // is zero, or the shift limit has been reached.
    always_comb begin
        nmi_stop = (ac_q[WIDTH-1] != ac_q[WIDTH-2])
                || ({ac_q, mq_q} == '0)
                || (sc_q == SCBITS'(NMI_MAX));
    end
`endif

    // Next-state, datapath load/step and step-counter control.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        ac_d    = ac_q;
        mq_d    = mq_q;
        l_d     = l_q;
        sc_d    = sc_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    op_d    = eae_op_e'(op);
                    ac_d    = ac_in;
                    mq_d    = mq_in;
                    l_d     = l_in;
                    sc_d    = (eae_op_e'(op) == EAE_NMI) ? '0 : count;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (op_q == EAE_NMI) begin
`ifdef EAE_NMI_EN
                    if (nmi_stop) begin
                        state_d = ST_DONE;
                    end else begin
                        ac_d = step_ac;
                        mq_d = step_mq;
                        l_d  = step_l;
                        sc_d = sc_q + SCBITS'(1);
                    end
`else
                    state_d = ST_DONE;
`endif
                end else begin
                    ac_d = step_ac;
                    mq_d = step_mq;
                    l_d  = step_l;
                    // The step taken with SC==0 is the final one; SC stays at 0.
                    if (sc_q == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        sc_d = sc_q - SCBITS'(1);
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            op_q    <= EAE_SHL;
            ac_q    <= '0;
            mq_q    <= '0;
            l_q     <= 1'b0;
            sc_q    <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            ac_q    <= ac_d;
            mq_q    <= mq_d;
            l_q     <= l_d;
            sc_q    <= sc_d;
        end
    end

    assign busy   = (state_q == ST_SHIFT);
    assign done   = (state_q == ST_DONE);
    assign ac_out = oe ? ac_q : 'z;
    assign mq_out = mq_q;
    assign l_out  = l_q;
    assign sc_out = sc_q;

endmodule

// File: tb/tb_eae_shifter.sv
// Scoreboard bench for eae_shifter: a driver issues operations and pushes the
// result predicted by a chain-arithmetic reference model; a monitor pops and
// compares whenever done is presented.
module tb_eae_shifter;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [4:0]  count;
    logic [11:0] ac_in;
    logic [11:0] mq_in;
    logic        l_in;
    logic        oe;
    wire  [11:0] ac_out;
    logic [11:0] mq_out;
    logic        l_out;
    logic [4:0]  sc_out;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;
    int unsigned cyc = 0;

    typedef struct {
        logic [11:0] ac;
        logic [11:0] mq;
        logic        l;
        logic [4:0]  sc;
        int unsigned lat;
        int unsigned done_cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    eae_shifter #(
        .WIDTH  (12),
        .SCBITS (5)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .count  (count),
        .ac_in  (ac_in),
        .mq_in  (mq_in),
        .l_in   (l_in),
        .oe     (oe),
        .ac_out (ac_out),
        .mq_out (mq_out),
        .l_out  (l_out),
        .sc_out (sc_out),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0o exp=%0o (cycle %0d)", name, got, exp, cyc);
        end
    endfunction

    // Reference: whole-chain arithmetic on the 25-bit L:AC:MQ value.
    function automatic exp_t model(input logic [1:0] o, input logic [4:0] n,
                                   input logic [11:0] a, input logic [11:0] m, input logic li);
        exp_t        e;
        logic [24:0] ch;
        logic [23:0] w;
        logic signed [23:0] sw;
        int unsigned steps;
        int unsigned k;
        steps = int'(n) + 1;
        w     = {a, m};
        e.l   = li;
        e.sc  = 5'd0;
        e.lat = steps + 1;
        e.done_cyc = 0;
        k = 0;
        case (o)
            2'b00: begin
                ch  = {li, a, m};
                ch  = ch << steps;
                e.l = ch[24];
                w   = ch[23:0];
            end
            2'b01: begin
                sw  = {a, m};
                sw  = sw >>> steps;
                w   = sw;
                e.l = a[11];
            end
            2'b10: begin
                w   = {a, m} >> steps;
                e.l = 1'b0;
            end
            default: begin
`ifdef EAE_NMI_EN
                while (k < 23 && w != 24'd0 && w[23] == w[22]) begin
                    e.l = w[23];
                    w   = w << 1;
                    k++;
                end
                e.sc  = 5'(k);
                e.lat = k + 2;
`else
                e.lat = 2;
`endif
            end
        endcase
        e.ac = w[23:12];
        e.mq = w[11:0];
        return e;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding prediction.
    always @(negedge clk) begin
        if (!reset && done) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_done got=1 exp=0 (cycle %0d)", cyc);
            end else begin
                mon_e = sb.pop_front();
                chk("done.ac", 32'(ac_out), 32'(mon_e.ac));
                chk("done.mq", 32'(mq_out), 32'(mon_e.mq));
                chk("done.l", 32'(l_out), 32'(mon_e.l));
                chk("done.sc", 32'(sc_out), 32'(mon_e.sc));
                chk("done.latency", cyc, mon_e.done_cyc);
                chk("done.busy_low", 32'(busy), 32'd0);
            end
        end
    end

    exp_t last_e;

    // Issue one operation, wait for completion, then check the held result
    // one cycle later (IDLE). Returns positioned so that an immediate call
    // presents start in the cycle after done.
    task automatic issue(input logic [1:0] o, input logic [4:0] n, input logic [11:0] a,
                         input logic [11:0] m, input logic li, input bit hold);
        exp_t e;
        int   k;
        e = model(o, n, a, m, li);
        e.done_cyc = cyc + e.lat;
        sb.push_back(e);
        last_e = e;
        op = o; count = n; ac_in = a; mq_in = m; l_in = li;
        start = 1'b1;
        @(negedge clk);
        start = hold;
        k = 0;
        while (!done && k < 80) begin
            if (hold) begin
                op = 2'($urandom); count = 5'($urandom);
                ac_in = 12'($urandom); mq_in = 12'($urandom); l_in = 1'($urandom);
            end
            @(negedge clk);
            k++;
        end
        start = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL done_timeout got=0 exp=1 (cycle %0d)", cyc);
            reset = 1'b1;
            @(negedge clk);
            reset = 1'b0;
            sb.delete();
        end
        @(negedge clk);
        chk("hold.ac", 32'(ac_out), 32'(e.ac));
        chk("hold.mq", 32'(mq_out), 32'(e.mq));
        chk("hold.l", 32'(l_out), 32'(e.l));
        chk("hold.sc", 32'(sc_out), 32'(e.sc));
        chk("hold.busy", 32'(busy), 32'd0);
        chk("hold.done", 32'(done), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; start = 1'b0; oe = 1'b1; op = 2'b00; count = 5'd0;
        ac_in = 12'o0; mq_in = 12'o0; l_in = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset.ac", 32'(ac_out), 32'd0);
        chk("reset.mq", 32'(mq_out), 32'd0);
        chk("reset.l", 32'(l_out), 32'd0);
        chk("reset.sc", 32'(sc_out), 32'd0);
        chk("reset.busy", 32'(busy), 32'd0);
        chk("reset.done", 32'(done), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Directed cases; the SHL is held on start to prove it is ignored.
        issue(2'b00, 5'd0,  12'o7777, 12'o0001, 1'b0, 1'b1);
        issue(2'b01, 5'd2,  12'o4000, 12'o0000, 1'b0, 1'b0);
        issue(2'b10, 5'd23, 12'o0003, 12'o0000, 1'b1, 1'b0);
        issue(2'b11, 5'd7,  12'o0001, 12'o0000, 1'b0, 1'b0);
        issue(2'b11, 5'd3,  12'o0000, 12'o0000, 1'b1, 1'b0);
        issue(2'b11, 5'd0,  12'o7777, 12'o7777, 1'b0, 1'b1);
        issue(2'b10, 5'd31, 12'o7777, 12'o7777, 1'b1, 1'b0);
        issue(2'b00, 5'd31, 12'o7777, 12'o7777, 1'b1, 1'b0);

        // Output enable: AC released, MQ and L still driven.
        issue(2'b00, 5'd0, 12'o7777, 12'o0001, 1'b0, 1'b0);
        oe = 1'b0;
        #1;
        chk("oe0.ac_released", 32'((ac_out === 12'bz) || (ac_out === 12'o0)), 32'd1);
        chk("oe0.mq", 32'(mq_out), 32'(last_e.mq));
        chk("oe0.l", 32'(l_out), 32'(last_e.l));
        oe = 1'b1;
        #1;
        chk("oe1.ac", 32'(ac_out), 32'(last_e.ac));
        @(negedge clk);

        // Reset mid-SHIFT: no prediction pushed, so any done would be flagged.
        op = 2'b10; count = 5'd20; ac_in = 12'o5252; mq_in = 12'o1234; l_in = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("midshift.busy_before", 32'(busy), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("midreset.ac", 32'(ac_out), 32'd0);
        chk("midreset.mq", 32'(mq_out), 32'd0);
        chk("midreset.l", 32'(l_out), 32'd0);
        chk("midreset.sc", 32'(sc_out), 32'd0);
        chk("midreset.busy", 32'(busy), 32'd0);
        chk("midreset.done", 32'(done), 32'd0);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("postreset.done", 32'(done), 32'd0);

        // Randomized operations, back-to-back or with short gaps.
        for (int i = 0; i < 40; i++) begin
            logic [11:0] a;
            a = 12'($urandom);
            if (($urandom % 3) == 0) a = a >> ($urandom % 12);
            issue(2'($urandom), 5'($urandom), a, 12'($urandom), 1'($urandom), 1'($urandom));
            repeat ($urandom % 3) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        chk("scoreboard.empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
